// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: arbitrates d-cache misses,
// EX mispredicts, load-use hazards and i-cache misses, and keeps stall/flush counters.
module hazard_controller #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_miss,
    input  logic             d_miss,
    input  logic             ex_mispredict,
    input  logic             ex_is_load,
    input  logic             ex_uses_rw,
    input  logic [4:0]       ex_rw_addr,
    input  logic             id_uses_rs,
    input  logic [4:0]       id_rs_addr,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rt_addr,
    input  logic             cnt_clear,
    output logic             if_stall,
    output logic             i2d_stall,
    output logic             i2d_flush,
    output logic             d2e_stall,
    output logic             d2e_flush,
    output logic             e2m_stall,
    output logic             e2m_flush,
    output logic             m2w_stall,
    output logic             m2w_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [2:0]       BUBBLE_RELOAD = 3'(LOAD_USE_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

    logic [2:0]       bubble_cnt_q, bubble_cnt_d;
    logic             squash_pend_q, squash_pend_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic lu;
    logic flush_inc;
    logic if_stall_c, i2d_stall_c, i2d_flush_c, d2e_stall_c, d2e_flush_c;
    logic e2m_stall_c, m2w_flush_c;

    assign lu = ex_is_load & ex_uses_rw & (ex_rw_addr != 5'd0) &
                ((id_uses_rs & (id_rs_addr == ex_rw_addr)) |
                 (id_uses_rt & (id_rt_addr == ex_rw_addr)));

    always_comb begin
        if_stall_c    = 1'b0;
        i2d_stall_c   = 1'b0;
        i2d_flush_c   = 1'b0;
        d2e_stall_c   = 1'b0;
        d2e_flush_c   = 1'b0;
        e2m_stall_c   = 1'b0;
        m2w_flush_c   = 1'b0;
        flush_inc     = 1'b0;
        bubble_cnt_d  = bubble_cnt_q;
        squash_pend_d = squash_pend_q;

        if (d_miss) begin
            if_stall_c  = 1'b1;
            i2d_stall_c = 1'b1;
            d2e_stall_c = 1'b1;
            e2m_stall_c = 1'b1;
            m2w_flush_c = 1'b1;
        end else if (ex_mispredict) begin
            i2d_flush_c  = 1'b1;
            d2e_flush_c  = 1'b1;
            bubble_cnt_d = 3'd0;
            flush_inc    = 1'b1;
            if (i_miss) squash_pend_d = 1'b1;
        end else if (lu || (bubble_cnt_q != 3'd0)) begin
            // I->D is held, so a pending squash must survive until the PC moves again.
            if_stall_c  = 1'b1;
            i2d_stall_c = 1'b1;
            d2e_flush_c = 1'b1;
            if (bubble_cnt_q == 3'd0) bubble_cnt_d = BUBBLE_RELOAD;
            else                      bubble_cnt_d = bubble_cnt_q - 3'd1;
        end else if (i_miss || squash_pend_q) begin
            // The first fetch after the miss is still wrong-path, so it is squashed too.
            i2d_flush_c = 1'b1;
            if (!i_miss) squash_pend_d = 1'b0;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (cnt_clear) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end else begin
            if (if_stall_c && (stall_cycles_q != CNT_MAX)) stall_cycles_d = stall_cycles_q + 1'b1;
            if (flush_inc && (flush_events_q != CNT_MAX))  flush_events_d = flush_events_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q   <= 3'd0;
            squash_pend_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            bubble_cnt_q   <= bubble_cnt_d;
            squash_pend_q  <= squash_pend_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // Controls are forced low while reset is held, whatever the inputs are doing.
    assign if_stall     = rst_n & if_stall_c;
    assign i2d_stall    = rst_n & i2d_stall_c;
    assign i2d_flush    = rst_n & i2d_flush_c;
    assign d2e_stall    = rst_n & d2e_stall_c;
    assign d2e_flush    = rst_n & d2e_flush_c;
    assign e2m_stall    = rst_n & e2m_stall_c;
    assign e2m_flush    = 1'b0;
    assign m2w_stall    = 1'b0;
    assign m2w_flush    = rst_n & m2w_flush_c;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: three instances (1 bubble, 3 bubbles,
// 4-bit counters) share one stimulus stream; expected values are hand-computed.
module tb_hazard_controller;

    logic       clk;
    logic       rst_n;
    logic       i_miss, d_miss, ex_mispredict, ex_is_load, ex_uses_rw;
    logic [4:0] ex_rw_addr, id_rs_addr, id_rt_addr;
    logic       id_uses_rs, id_uses_rt, cnt_clear;

    // Control vector order: if_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
    // e2m_stall, e2m_flush, m2w_stall, m2w_flush.
    localparam logic [8:0] C_IDLE  = 9'b000000000;
    localparam logic [8:0] C_LU    = 9'b110010000;
    localparam logic [8:0] C_DMISS = 9'b110101001;
    localparam logic [8:0] C_MISP  = 9'b001010000;
    localparam logic [8:0] C_IFL   = 9'b001000000;

    logic [8:0]  ctl1, ctl3, ctl4;
    logic [31:0] stall1, flush1, stall3, flush3;
    logic [3:0]  stall4, flush4;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_controller #(.LOAD_USE_BUBBLES(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .d_miss(d_miss),
        .ex_mispredict(ex_mispredict), .ex_is_load(ex_is_load), .ex_uses_rw(ex_uses_rw),
        .ex_rw_addr(ex_rw_addr), .id_uses_rs(id_uses_rs), .id_rs_addr(id_rs_addr),
        .id_uses_rt(id_uses_rt), .id_rt_addr(id_rt_addr), .cnt_clear(cnt_clear),
        .if_stall(ctl1[8]), .i2d_stall(ctl1[7]), .i2d_flush(ctl1[6]),
        .d2e_stall(ctl1[5]), .d2e_flush(ctl1[4]), .e2m_stall(ctl1[3]),
        .e2m_flush(ctl1[2]), .m2w_stall(ctl1[1]), .m2w_flush(ctl1[0]),
        .stall_cycles(stall1), .flush_events(flush1)
    );

    hazard_controller #(.LOAD_USE_BUBBLES(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .d_miss(d_miss),
        .ex_mispredict(ex_mispredict), .ex_is_load(ex_is_load), .ex_uses_rw(ex_uses_rw),
        .ex_rw_addr(ex_rw_addr), .id_uses_rs(id_uses_rs), .id_rs_addr(id_rs_addr),
        .id_uses_rt(id_uses_rt), .id_rt_addr(id_rt_addr), .cnt_clear(cnt_clear),
        .if_stall(ctl3[8]), .i2d_stall(ctl3[7]), .i2d_flush(ctl3[6]),
        .d2e_stall(ctl3[5]), .d2e_flush(ctl3[4]), .e2m_stall(ctl3[3]),
        .e2m_flush(ctl3[2]), .m2w_stall(ctl3[1]), .m2w_flush(ctl3[0]),
        .stall_cycles(stall3), .flush_events(flush3)
    );

    hazard_controller #(.LOAD_USE_BUBBLES(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .d_miss(d_miss),
        .ex_mispredict(ex_mispredict), .ex_is_load(ex_is_load), .ex_uses_rw(ex_uses_rw),
        .ex_rw_addr(ex_rw_addr), .id_uses_rs(id_uses_rs), .id_rs_addr(id_rs_addr),
        .id_uses_rt(id_uses_rt), .id_rt_addr(id_rt_addr), .cnt_clear(cnt_clear),
        .if_stall(ctl4[8]), .i2d_stall(ctl4[7]), .i2d_flush(ctl4[6]),
        .d2e_stall(ctl4[5]), .d2e_flush(ctl4[4]), .e2m_stall(ctl4[3]),
        .e2m_flush(ctl4[2]), .m2w_stall(ctl4[1]), .m2w_flush(ctl4[0]),
        .stall_cycles(stall4), .flush_events(flush4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clr_in();
        i_miss = 0; d_miss = 0; ex_mispredict = 0; ex_is_load = 0; ex_uses_rw = 0;
        ex_rw_addr = 0; id_uses_rs = 0; id_rs_addr = 0; id_uses_rt = 0; id_rt_addr = 0;
        cnt_clear = 0;
    endtask

    task automatic drive_lu(input logic [4:0] ex_a, input logic [4:0] rs_a);
        ex_is_load = 1; ex_uses_rw = 1; ex_rw_addr = ex_a;
        id_uses_rs = 1; id_rs_addr = rs_a;
    endtask

    initial begin
        rst_n = 0;
        clr_in();
        repeat (2) @(negedge clk);
        d_miss = 1;
        #1 chk("rst_ctl1", 32'(ctl1), 32'(C_IDLE));
        chk("rst_ctl4", 32'(ctl4), 32'(C_IDLE));
        d_miss = 0;

        @(negedge clk); rst_n = 1;
        #1 chk("post_rst_ctl", 32'(ctl1), 32'(C_IDLE));
        chk("post_rst_stall", stall1, 0);
        chk("post_rst_flush", flush1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 chk("idle_ctl", 32'(ctl1), 32'(C_IDLE));
        end
        chk("idle_stall", stall1, 0);

        // Load-use on rs: one bubble in u_dut1, three in u_dut3.
        @(negedge clk); drive_lu(5'd8, 5'd8);
        #1 chk("lu_rs_ctl1", 32'(ctl1), 32'(C_LU));
        chk("lu_rs_ctl3", 32'(ctl3), 32'(C_LU));
        @(negedge clk); clr_in();
        #1 chk("lu_after_ctl1", 32'(ctl1), 32'(C_IDLE));
        chk("lu_after_stall1", stall1, 1);
        chk("lu3_b2_ctl3", 32'(ctl3), 32'(C_LU));
        @(negedge clk);
        #1 chk("lu3_b1_ctl3", 32'(ctl3), 32'(C_LU));
        @(negedge clk);
        #1 chk("lu3_done_ctl3", 32'(ctl3), 32'(C_IDLE));
        chk("lu3_stall3", stall3, 3);

        // Load-use through rt only.
        @(negedge clk); drive_lu(5'd5, 5'd6); id_uses_rt = 1; id_rt_addr = 5'd5;
        #1 chk("lu_rt_ctl1", 32'(ctl1), 32'(C_LU));
        @(negedge clk); clr_in();
        #1 chk("lu_rt_after", 32'(ctl1), 32'(C_IDLE));
        chk("lu_rt_stall1", stall1, 2);
        repeat (2) @(negedge clk);
        #1 chk("lu_rt_ctl3_done", 32'(ctl3), 32'(C_IDLE));
        chk("lu_rt_stall3", stall3, 6);

        // Near-miss hazards that must not stall.
        @(negedge clk); drive_lu(5'd0, 5'd0);
        #1 chk("nolu_r0_ctl1", 32'(ctl1), 32'(C_IDLE));
        chk("nolu_r0_ctl3", 32'(ctl3), 32'(C_IDLE));
        @(negedge clk); drive_lu(5'd8, 5'd8); id_uses_rs = 0;
        #1 chk("nolu_nors", 32'(ctl1), 32'(C_IDLE));
        @(negedge clk); id_uses_rs = 1; ex_is_load = 0;
        #1 chk("nolu_noload", 32'(ctl1), 32'(C_IDLE));
        @(negedge clk); ex_is_load = 1; ex_uses_rw = 0;
        #1 chk("nolu_norw", 32'(ctl1), 32'(C_IDLE));

        // d_miss outranks a mispredict; mispredict applies on release.
        @(negedge clk); clr_in(); d_miss = 1; ex_mispredict = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("dmiss_ctl", 32'(ctl1), 32'(C_DMISS));
            chk("dmiss_flush", flush1, 0);
            @(negedge clk);
        end
        d_miss = 0;
        #1 chk("misp_rel_ctl", 32'(ctl1), 32'(C_MISP));
        chk("misp_rel_stall", stall1, 7);
        @(negedge clk); clr_in();
        #1 chk("misp_done_ctl", 32'(ctl1), 32'(C_IDLE));
        chk("misp_flush1", flush1, 1);

        // Mispredict during an i-miss leaves a pending squash.
        @(negedge clk); ex_mispredict = 1; i_miss = 1;
        #1 chk("misp_imiss_ctl", 32'(ctl1), 32'(C_MISP));
        @(negedge clk); ex_mispredict = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("imiss_ctl", 32'(ctl1), 32'(C_IFL));
            @(negedge clk);
        end
        i_miss = 0;
        #1 chk("squash_ctl", 32'(ctl1), 32'(C_IFL));
        @(negedge clk);
        #1 chk("squash_done_ctl", 32'(ctl1), 32'(C_IDLE));
        chk("squash_flush1", flush1, 2);

        // Asynchronous reset in the middle of a 3-bubble sequence.
        @(negedge clk); drive_lu(5'd9, 5'd9);
        #1 chk("mid_lu_ctl3", 32'(ctl3), 32'(C_LU));
        @(negedge clk); clr_in();
        #1 chk("mid_b2_ctl3", 32'(ctl3), 32'(C_LU));
        #2 rst_n = 0;
        #1 chk("mid_rst_ctl3", 32'(ctl3), 32'(C_IDLE));
        chk("mid_rst_stall3", stall3, 0);
        chk("mid_rst_flush1", flush1, 0);
        @(negedge clk); rst_n = 1;
        #1 chk("mid_rel_ctl3", 32'(ctl3), 32'(C_IDLE));

        // Saturation of the 4-bit counter under a long d_miss.
        @(negedge clk); d_miss = 1;
        #1 chk("sat_ctl4", 32'(ctl4), 32'(C_DMISS));
        repeat (15) @(negedge clk);
        #1 chk("sat15_stall4", 32'(stall4), 15);
        repeat (2) @(negedge clk);
        #1 chk("sat17_stall4", 32'(stall4), 15);
        chk("sat17_stall1", stall1, 17);
        cnt_clear = 1;
        #1 chk("clr_ctl4", 32'(ctl4), 32'(C_DMISS));
        @(negedge clk); cnt_clear = 0;
        #1 chk("clr_stall4", 32'(stall4), 0);
        chk("clr_stall1", stall1, 0);
        @(negedge clk); clr_in();
        #1 chk("post_clr_stall4", 32'(stall4), 1);
        @(negedge clk);
        #1 chk("post_clr_idle", 32'(stall4), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
